uart_rx_autobaud: RTL and testbench

- Serial receive front end for the debug UART command decoder.
- Deserialises the host's 8N1 stream into one byte per strobe: `id` plus a one-cycle `dix`.
- Bit time is learned from the first character, which must be "a" (0x61) or "i" (0x69). Both have bit0=1, so that character's start bit is exactly one bit time low.
- The learned period is held until reset or a line break.

---
 rtl/uart_rx_autobaud.sv | 137 +++++++++++++
 tb/tb_uart_rx_autobaud.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/uart_rx_autobaud.sv
// 8N1 serial receiver that learns its bit period from the start bit of the
// first character ("a" or "i") and then deserialises bytes at that rate.
module uart_rx_autobaud #(
    parameter int CNT_W   = 16,
    parameter int MIN_BIT = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             rxd,
    output logic [7:0]       id,
    output logic             dix,
    output logic             ferr,
    output logic             locked,
    output logic [CNT_W-1:0] bitlen
);

    typedef enum logic [2:0] {HUNT, MEASURE, IDLE, START, DATA, STOP} state_t;

    state_t           state;
    logic             rx_p0, rx_p1, rxs_p2;
    logic             rxs, fall, expired;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       idx;
    logic [7:0]       shreg;

    assign rxs     = rx_p1;
    assign fall    = rxs_p2 & ~rxs;
    assign expired = (cnt <= CNT_W'(1));

    // Synchroniser stages; preset high so reset never fakes a falling edge
    always_ff @(posedge clk) begin
        if (reset) begin
            rx_p0  <= 1'b1;
            rx_p1  <= 1'b1;
            rxs_p2 <= 1'b1;
        end else begin
            rx_p0  <= rxd;
            rx_p1  <= rx_p0;
            rxs_p2 <= rx_p1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= HUNT;
            cnt    <= '0;
            idx    <= '0;
            shreg  <= '0;
            id     <= '0;
            dix    <= 1'b0;
            ferr   <= 1'b0;
            locked <= 1'b0;
            bitlen <= '0;
        end else begin
            dix  <= 1'b0;
            ferr <= 1'b0;
            case (state)
                HUNT: begin
                    if (fall) begin
                        cnt   <= CNT_W'(1);
                        state <= MEASURE;
                    end
                end
                MEASURE: begin
                    // The rising edge ends the start bit and is the first cycle of bit0
                    if (rxs) begin
                        if (cnt < CNT_W'(MIN_BIT)) begin
                            state <= HUNT;
                        end else begin
                            bitlen <= cnt;
                            locked <= 1'b1;
                            cnt    <= cnt >> 1;
                            idx    <= '0;
                            state  <= DATA;
                        end
                    end else if (&cnt) begin
                        state <= HUNT;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                IDLE: begin
                    if (fall) begin
                        cnt   <= bitlen >> 1;
                        state <= START;
                    end
                end
                START: begin
                    if (expired) begin
                        if (rxs) begin
                            state <= IDLE;
                        end else begin
                            idx   <= '0;
                            cnt   <= bitlen;
                            state <= DATA;
                        end
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                DATA: begin
                    if (expired) begin
                        shreg[idx] <= rxs;
                        cnt        <= bitlen;
                        idx        <= idx + 1'b1;
                        if (idx == 3'd7) state <= STOP;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                STOP: begin
                    if (expired) begin
                        if (rxs) begin
                            id    <= shreg;
                            dix   <= 1'b1;
                            state <= IDLE;
                        end else begin
                            ferr <= 1'b1;
                            // An all-zero frame with a low stop bit is a line break
                            if (shreg == 8'h00) begin
                                locked <= 1'b0;
                                bitlen <= '0;
                                state  <= HUNT;
                            end else begin
                                state <= IDLE;
                            end
                        end
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: state <= HUNT;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx_autobaud.sv
// Scoreboard bench: stimulus pushes expected bytes/framing errors, monitors pop
// and compare whenever a receiver strobes dix or ferr.
module tb_uart_rx_autobaud;

    localparam int FERR_TAG = 256;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        rxd_a = 1'b1, rxd_b = 1'b1;
    logic [7:0]  id_a, id_b;
    logic        dix_a, dix_b, ferr_a, ferr_b, locked_a, locked_b;
    logic [15:0] bitlen_a;
    logic [7:0]  bitlen_b;

    int n_chk = 0;
    int n_pass = 0;
    int cyc = 0;
    int exp_a[$];
    int exp_b[$];
    int dix_cyc_a[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    uart_rx_autobaud #(.CNT_W(16), .MIN_BIT(4)) u_a (
        .clk(clk), .reset(reset), .rxd(rxd_a), .id(id_a), .dix(dix_a),
        .ferr(ferr_a), .locked(locked_a), .bitlen(bitlen_a)
    );

    uart_rx_autobaud #(.CNT_W(8), .MIN_BIT(4)) u_b (
        .clk(clk), .reset(reset), .rxd(rxd_b), .id(id_b), .dix(dix_b),
        .ferr(ferr_b), .locked(locked_b), .bitlen(bitlen_b)
    );

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    endtask

    // Monitors
    always @(negedge clk) begin
        if (dix_a) begin
            dix_cyc_a.push_back(cyc);
            if (exp_a.size() == 0) chk("unexpected dix A", int'(id_a), -1);
            else                   chk("dix A byte", int'(id_a), exp_a.pop_front());
        end
        if (ferr_a) begin
            if (exp_a.size() == 0) chk("unexpected ferr A", FERR_TAG, -1);
            else                   chk("ferr A event", FERR_TAG, exp_a.pop_front());
        end
        if (dix_b) begin
            if (exp_b.size() == 0) chk("unexpected dix B", int'(id_b), -1);
            else                   chk("dix B byte", int'(id_b), exp_b.pop_front());
        end
        if (ferr_b) begin
            if (exp_b.size() == 0) chk("unexpected ferr B", FERR_TAG, -1);
            else                   chk("ferr B event", FERR_TAG, exp_b.pop_front());
        end
    end

    task automatic drive(input int which, input logic v, input int n);
        if (which == 0) rxd_a = v;
        else            rxd_b = v;
        repeat (n) @(negedge clk);
    endtask

    task automatic send_frame(input int which, input logic [7:0] b, input int bt, input logic stop_v);
        drive(which, 1'b0, bt);
        for (int i = 0; i < 8; i++) drive(which, b[i], bt);
        drive(which, stop_v, bt);
    endtask

    initial begin
        repeat (4) @(negedge clk);
        chk("reset id", int'(id_a), 0);
        chk("reset dix", int'(dix_a), 0);
        chk("reset ferr", int'(ferr_a), 0);
        chk("reset locked", int'(locked_a), 0);
        chk("reset bitlen", int'(bitlen_a), 0);
        reset = 1'b0;
        repeat (5) @(negedge clk);

        // Learn 16 clk/bit from "a"
        exp_a.push_back(8'h61);
        send_frame(0, 8'h61, 16, 1'b1);
        drive(0, 1'b1, 40);
        chk("a locked", int'(locked_a), 1);
        chk("a bitlen", int'(bitlen_a), 16);
        chk("a id", int'(id_a), 8'h61);

        // Back-to-back "r","w" with no idle gap
        dix_cyc_a.delete();
        exp_a.push_back(8'h72);
        exp_a.push_back(8'h77);
        send_frame(0, 8'h72, 16, 1'b1);
        send_frame(0, 8'h77, 16, 1'b1);
        drive(0, 1'b1, 40);
        chk("rw dix count", dix_cyc_a.size(), 2);
        if (dix_cyc_a.size() >= 2) chk("rw spacing", dix_cyc_a[1] - dix_cyc_a[0], 160);

        // Framing error, then break
        exp_a.push_back(FERR_TAG);
        send_frame(0, 8'h55, 16, 1'b0);
        drive(0, 1'b1, 40);
        chk("ferr id held", int'(id_a), 8'h77);
        chk("ferr still locked", int'(locked_a), 1);
        exp_a.push_back(FERR_TAG);
        send_frame(0, 8'h00, 16, 1'b0);
        drive(0, 1'b1, 40);
        chk("break locked", int'(locked_a), 0);
        chk("break bitlen", int'(bitlen_a), 0);

        // Glitch rejected, then relearn at 20 from "i"
        drive(0, 1'b0, 2);
        drive(0, 1'b1, 30);
        chk("glitch locked", int'(locked_a), 0);
        exp_a.push_back(8'h69);
        send_frame(0, 8'h69, 20, 1'b1);
        drive(0, 1'b1, 40);
        chk("i bitlen", int'(bitlen_a), 20);
        chk("i locked", int'(locked_a), 1);
        chk("i id", int'(id_a), 8'h69);

        // CNT_W=8: stuck-low line must not lock
        drive(1, 1'b0, 300);
        drive(1, 1'b1, 30);
        chk("stuck locked B", int'(locked_b), 0);
        chk("stuck bitlen B", int'(bitlen_b), 0);
        exp_b.push_back(8'h61);
        send_frame(1, 8'h61, 10, 1'b1);
        drive(1, 1'b1, 30);
        chk("B locked", int'(locked_b), 1);
        chk("B bitlen", int'(bitlen_b), 10);

        // Reset in the middle of bit 4 of 0xF5; remaining bits stay high
        drive(0, 1'b0, 20);
        for (int i = 0; i < 4; i++) drive(0, (8'hF5 >> i) & 8'h01, 20);
        drive(0, 1'b1, 10);
        reset = 1'b1;
        @(negedge clk);
        chk("midreset id", int'(id_a), 0);
        chk("midreset dix", int'(dix_a), 0);
        chk("midreset locked", int'(locked_a), 0);
        chk("midreset bitlen", int'(bitlen_a), 0);
        reset = 1'b0;
        drive(0, 1'b1, 200);
        chk("post reset locked", int'(locked_a), 0);

        chk("queue A drained", exp_a.size(), 0);
        chk("queue B drained", exp_b.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
